// File: rtl/vga_sync_controller.sv
// vga_sync_controller: pixel-tick divider plus 800x525 raster scanner for a
// 640x480@60Hz display. All outputs are registered so x/y, video_on and the
// active-low sync pins change together on the same pixel-tick edge.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt port.
module vga_sync_controller #(
    parameter int DIV       = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [3:0] div_cnt_q, div_cnt_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       at_frame_end;

    // Tick is decoded straight from the divider register: one clk in every DIV.
    assign p_tick = (div_cnt_q == DIV_LAST);
    assign at_frame_end = (x_q == H_LAST) && (y_q == V_LAST);

    // Next-state for divider and raster; sync/blank derive from the next counters
    // so they register alongside the x/y they describe.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d    = !((x_d >= HS_START) && (x_d <= HS_END));
        vsync_d    = !((y_d >= VS_START) && (y_d <= VS_END));
    end

    // Divider and raster registers; reset parks the scan on the last pixel so the
    // first tick lands on (0,0).
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q  <= 4'd0;
            x_q        <= H_LAST;
            y_q        <= V_LAST;
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            div_cnt_q  <= div_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign video_on = video_on_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Count frames on the tick that wraps the raster back to (0,0).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (p_tick && at_frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Frame counter register.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) frame_cnt_q <= 8'd0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = at_frame_end;
`endif

endmodule

// File: tb/tb_vga_sync_controller.sv
// tb_vga_sync_controller: randomized reset pulses plus a long free run, checked
// every cycle against a model that derives the raster position arithmetically
// from the number of clk edges since reset release. A small raster keeps the
// 257-frame run short.
module tb_vga_sync_controller;

    localparam int DIV = 4;
    localparam int HD = 4, HF = 1, HS = 2, HB = 1;
    localparam int VD = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       p_tick;
    logic [9:0] x, y;
    logic       video_on, hsync, vsync;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    longint n_edges = 0;
    bit model_on = 1'b0;

    vga_sync_controller #(
        .DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .p_tick    (p_tick),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .hsync     (hsync),
        .vsync     (vsync)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input int act, input int exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Edges since release; the whole reference state is a function of this count.
    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) n_edges <= 0;
        else          n_edges <= n_edges + 1;
    end

    // Per-cycle compare against the arithmetic model.
    always @(negedge clk_100MHz) begin
        if (model_on) begin
            int ex, ey, evo, ehs, evs, ept;
            longint ticks, pos;
`ifdef VGA_FRAME_CNT_EN
            int efc;
`endif
            if (!reset_n) begin
                ex = HT - 1; ey = VT - 1; evo = 0; ehs = 1; evs = 1; ept = 0;
`ifdef VGA_FRAME_CNT_EN
                efc = 0;
`endif
            end else begin
                ticks = n_edges / DIV;
                pos   = (FT - 1 + ticks) % FT;
                ex    = int'(pos % HT);
                ey    = int'(pos / HT);
                evo   = (ex < HD && ey < VD) ? 1 : 0;
                ehs   = (ex >= HD + HF && ex < HD + HF + HS) ? 0 : 1;
                evs   = (ey >= VD + VF && ey < VD + VF + VS) ? 0 : 1;
                ept   = ((n_edges + 1) % DIV == 0) ? 1 : 0;
`ifdef VGA_FRAME_CNT_EN
                efc   = int'(((ticks + FT - 1) / FT) % 256);
`endif
            end
            vectors++;
            check("x", int'(x), ex);
            check("y", int'(y), ey);
            check("video_on", int'(video_on), evo);
            check("hsync", int'(hsync), ehs);
            check("vsync", int'(vsync), evs);
            check("p_tick", int'(p_tick), ept);
`ifdef VGA_FRAME_CNT_EN
            check("frame_cnt", int'(frame_cnt), efc);
`endif
        end
    end

    // Release reset just after a rising edge and pin the first-tick timing.
    task automatic release_and_pin();
        @(posedge clk_100MHz); #2 reset_n = 1'b1;
        @(negedge clk_100MHz);
        vectors++; check("pt_pre", int'(p_tick), 0);
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        vectors++; check("pt_tick1", int'(p_tick), 1);
        vectors++; check("x_pre_tick", int'(x), HT - 1);
        @(posedge clk_100MHz); @(negedge clk_100MHz);
        vectors++; check("x_first", int'(x), 0);
        vectors++; check("y_first", int'(y), 0);
        vectors++; check("vo_first", int'(video_on), 1);
        vectors++; check("pt_after", int'(p_tick), 0);
    endtask

    initial begin
        repeat (10) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        vectors++; check("rst_x", int'(x), HT - 1);
        vectors++; check("rst_y", int'(y), VT - 1);
        vectors++; check("rst_vo", int'(video_on), 0);
        vectors++; check("rst_hs", int'(hsync), 1);
        vectors++; check("rst_vs", int'(vsync), 1);
        vectors++; check("rst_pt", int'(p_tick), 0);
        model_on = 1'b1;
        release_and_pin();

        // Random mid-frame resets asserted between edges.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 500)) @(posedge clk_100MHz);
            #(1 + $urandom_range(0, 3)) reset_n = 1'b0;
            #1;
            vectors++; check("async_x", int'(x), HT - 1);
            vectors++; check("async_y", int'(y), VT - 1);
            vectors++; check("async_vo", int'(video_on), 0);
            repeat ($urandom_range(1, 4)) @(posedge clk_100MHz);
            release_and_pin();
        end

        // Clean run long enough to wrap the frame counter (257 frames).
        @(posedge clk_100MHz); #2 reset_n = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        release_and_pin();
        repeat (257 * FT * DIV + 40) @(posedge clk_100MHz);
        @(negedge clk_100MHz);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
